width_16to24: RTL and testbench

Width converter that sits directly downstream of the 8-to-16 stitching stage. It consumes its 16-bit valid-qualified words and repacks them MSB-first into 24-bit words: three inputs produce two outputs. An end-of-frame marker flushes any leftover bytes as a zero-padded final word. The output is tagged with last and pad-count sidebands for the next 24-bit consumer.

---
 rtl/width_16to24.sv | 115 +++++++++++
 tb/tb_width_16to24.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/width_16to24.sv
// Repacks a stream of 16-bit words into 24-bit MSB-first words (three in, two out).
// End-of-frame flushes leftover bytes as a padded final word tagged with last/pad sidebands.
module width_16to24 #(
   parameter logic [7:0] PAD_BYTE = 8'h00
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_in,
   input  logic [15:0] data_in,
   input  logic        last_in,
   output logic        valid_out,
   output logic [23:0] data_out,
   output logic        last_out,
   output logic [1:0]  pad_bytes
);

   // PEND: a one-word frame arrived during FLUSH and is emitted the cycle after it.
   typedef enum logic [2:0] {
      EMPTY  = 3'd0,
      HOLD16 = 3'd1,
      HOLD8  = 3'd2,
      FLUSH  = 3'd3,
      PEND   = 3'd4
   } state_t;

   state_t      state_reg, state_next;
   logic [15:0] buf_reg, buf_next;
   logic        valid_out_reg, valid_out_next;
   logic [23:0] data_out_reg, data_out_next;
   logic        last_out_reg, last_out_next;
   logic [1:0]  pad_bytes_reg, pad_bytes_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= EMPTY;
         buf_reg       <= 16'h0;
         valid_out_reg <= 1'b0;
         data_out_reg  <= 24'h0;
         last_out_reg  <= 1'b0;
         pad_bytes_reg <= 2'd0;
      end else begin
         state_reg     <= state_next;
         buf_reg       <= buf_next;
         valid_out_reg <= valid_out_next;
         data_out_reg  <= data_out_next;
         last_out_reg  <= last_out_next;
         pad_bytes_reg <= pad_bytes_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      buf_next       = buf_reg;
      valid_out_next = 1'b0;
      data_out_next  = data_out_reg;
      last_out_next  = 1'b0;
      pad_bytes_next = 2'd0;
      case (state_reg)
         EMPTY: begin
            if (valid_in) begin
               if (last_in) begin
                  valid_out_next = 1'b1;
                  data_out_next  = {data_in, PAD_BYTE};
                  last_out_next  = 1'b1;
                  pad_bytes_next = 2'd1;
               end else begin
                  buf_next   = data_in;
                  state_next = HOLD16;
               end
            end
         end
         HOLD16: begin
            if (valid_in) begin
               valid_out_next = 1'b1;
               data_out_next  = {buf_reg, data_in[15:8]};
               buf_next[7:0]  = data_in[7:0];
               state_next     = last_in ? FLUSH : HOLD8;
            end
         end
         HOLD8: begin
            if (valid_in) begin
               valid_out_next = 1'b1;
               data_out_next  = {buf_reg[7:0], data_in};
               last_out_next  = last_in;
               state_next     = EMPTY;
            end
         end
         FLUSH, PEND: begin
            // Both emit unconditionally from buf, so an incoming word may overwrite buf now.
            valid_out_next = 1'b1;
            last_out_next  = 1'b1;
            if (state_reg == FLUSH) begin
               data_out_next  = {buf_reg[7:0], PAD_BYTE, PAD_BYTE};
               pad_bytes_next = 2'd2;
            end else begin
               data_out_next  = {buf_reg, PAD_BYTE};
               pad_bytes_next = 2'd1;
            end
            if (valid_in) begin
               buf_next   = data_in;
               state_next = last_in ? PEND : HOLD16;
            end else begin
               state_next = EMPTY;
            end
         end
         default: state_next = EMPTY;
      endcase
   end

   assign valid_out = valid_out_reg;
   assign data_out  = data_out_reg;
   assign last_out  = last_out_reg;
   assign pad_bytes = pad_bytes_reg;

endmodule

// File: tb/tb_width_16to24.sv
// Directed and randomized checks of width_16to24 with PAD_BYTE 00 and FF instances.
// Random phase compares against a byte-queue model of the frame repacking rules.
module tb_width_16to24;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid_in = 1'b0;
   logic [15:0] data_in = 16'h0;
   logic        last_in = 1'b0;
   logic        valid_out, last_out, valid_out_ff, last_out_ff;
   logic [23:0] data_out, data_out_ff;
   logic [1:0]  pad_bytes, pad_bytes_ff;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic [23:0] d;
      logic        l;
      logic [1:0]  p;
   } exp_t;
   exp_t exp_q[$];
   logic [7:0] byte_q[$];

   always #5 clk = ~clk;

   width_16to24 #(.PAD_BYTE(8'h00)) dut (
      .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in), .last_in(last_in),
      .valid_out(valid_out), .data_out(data_out), .last_out(last_out), .pad_bytes(pad_bytes)
   );

   width_16to24 #(.PAD_BYTE(8'hFF)) dut_ff (
      .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in), .last_in(last_in),
      .valid_out(valid_out_ff), .data_out(data_out_ff), .last_out(last_out_ff), .pad_bytes(pad_bytes_ff)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [23:0] ff_pad(input logic [23:0] d, input logic [1:0] p);
      return (p == 2'd2) ? (d | 24'h00FFFF) : (p == 2'd1) ? (d | 24'h0000FF) : d;
   endfunction

   task automatic check_out(input string tag, input logic ev, input logic [23:0] ed,
                            input logic el, input logic [1:0] ep);
      check({tag, ".valid"}, 32'(valid_out), 32'(ev));
      check({tag, ".valid_ff"}, 32'(valid_out_ff), 32'(ev));
      check({tag, ".last"}, 32'(last_out), ev ? 32'(el) : 32'd0);
      check({tag, ".pad"}, 32'(pad_bytes), ev ? 32'(ep) : 32'd0);
      if (ev) begin
         check({tag, ".data"}, 32'(data_out), 32'(ed));
         check({tag, ".data_ff"}, 32'(data_out_ff), 32'(ff_pad(ed, ep)));
         check({tag, ".last_ff"}, 32'(last_out_ff), 32'(el));
         $display("word %h last %b pad %0d (%s)", data_out, last_out, pad_bytes, tag);
      end
   endtask

   // Apply one cycle of input; the expectation is the registered output after that edge.
   task automatic step(input string tag, input logic v, input logic [15:0] d, input logic l,
                       input logic ev, input logic [23:0] ed, input logic el, input logic [1:0] ep);
      valid_in = v;
      data_in  = d;
      last_in  = l;
      @(posedge clk);
      #1;
      check_out(tag, ev, ed, el, ep);
   endtask

   // Reference: bytes of the open frame accumulate; every three become a word, last flushes.
   task automatic model_beat(input logic [15:0] d, input logic l);
      exp_t e;
      byte_q.push_back(d[15:8]);
      byte_q.push_back(d[7:0]);
      while (byte_q.size() >= 3) begin
         e.d = {byte_q[0], byte_q[1], byte_q[2]};
         e.l = 1'b0;
         e.p = 2'd0;
         void'(byte_q.pop_front());
         void'(byte_q.pop_front());
         void'(byte_q.pop_front());
         exp_q.push_back(e);
      end
      if (l) begin
         if (byte_q.size() == 0) begin
            exp_q[exp_q.size() - 1].l = 1'b1;
         end else begin
            e.p = 2'(3 - byte_q.size());
            e.d = (byte_q.size() == 1) ? {byte_q[0], 16'h0} : {byte_q[0], byte_q[1], 8'h0};
            e.l = 1'b1;
            exp_q.push_back(e);
         end
         byte_q.delete();
      end
   endtask

   task automatic scoreboard_cycle(input string tag);
      exp_t e;
      if (valid_out) begin
         if (exp_q.size() == 0) begin
            check({tag, ".spurious"}, 32'(valid_out), 32'd0);
         end else begin
            e = exp_q.pop_front();
            check_out(tag, 1'b1, e.d, e.l, e.p);
         end
      end else begin
         check({tag, ".idle_last"}, 32'(last_out), 32'd0);
      end
   endtask

   initial begin
      // Reset values
      #2;
      check_out("reset", 1'b0, 24'h0, 1'b0, 2'd0);
      check("reset.data", 32'(data_out), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Continuous stream
      step("cont0", 1, 16'hA1B2, 0, 0, 24'h0, 0, 0);
      step("cont1", 1, 16'hC3D4, 0, 1, 24'hA1B2C3, 0, 0);
      step("cont2", 1, 16'hE5F6, 0, 1, 24'hD4E5F6, 0, 0);
      step("cont3", 0, 16'h0, 0, 0, 24'h0, 0, 0);
      check("hold.data", 32'(data_out), 32'h00D4E5F6);

      // Gapped stream
      for (int i = 0; i < 3; i++) begin
         logic [15:0] w;
         logic [23:0] e;
         w = (i == 0) ? 16'hA1B2 : (i == 1) ? 16'hC3D4 : 16'hE5F6;
         e = (i == 1) ? 24'hA1B2C3 : 24'hD4E5F6;
         step("gap_beat", 1, w, 0, i != 0, e, 0, 0);
         step("gap_idle", 0, 16'h0, 0, 0, 24'h0, 0, 0);
         step("gap_idle", 0, 16'h0, 0, 0, 24'h0, 0, 0);
      end

      // Single-word frame
      step("single", 1, 16'h1234, 1, 1, 24'h123400, 1, 1);
      step("single_idle", 0, 16'h0, 0, 0, 24'h0, 0, 0);

      // Two-word frame then immediate new frame during FLUSH
      step("two0", 1, 16'hAABB, 0, 0, 24'h0, 0, 0);
      step("two1", 1, 16'hCCDD, 1, 1, 24'hAABBCC, 0, 0);
      step("flush", 1, 16'h1122, 0, 1, 24'hDD0000, 1, 2);
      step("after_flush0", 1, 16'h3344, 0, 1, 24'h112233, 0, 0);
      step("after_flush1", 1, 16'h5566, 0, 1, 24'h445566, 0, 0);
      step("after_flush2", 0, 16'h0, 0, 0, 24'h0, 0, 0);

      // One-word frames arriving during FLUSH and back to back
      step("pend0", 1, 16'hAABB, 0, 0, 24'h0, 0, 0);
      step("pend1", 1, 16'hCCDD, 1, 1, 24'hAABBCC, 0, 0);
      step("pend2", 1, 16'h7788, 1, 1, 24'hDD0000, 1, 2);
      step("pend3", 1, 16'h99AA, 1, 1, 24'h778800, 1, 1);
      step("pend4", 0, 16'h0, 0, 1, 24'h99AA00, 1, 1);
      step("pend5", 0, 16'h0, 0, 0, 24'h0, 0, 0);

      // Three-word frame ends on a word boundary: no flush word
      step("three0", 1, 16'h0102, 0, 0, 24'h0, 0, 0);
      step("three1", 1, 16'h0304, 0, 1, 24'h010203, 0, 0);
      step("three2", 1, 16'h0506, 1, 1, 24'h040506, 1, 0);
      step("three3", 0, 16'h0, 0, 0, 24'h0, 0, 0);
      step("three4", 0, 16'h0, 0, 0, 24'h0, 0, 0);

      // Asynchronous reset while holding one byte
      step("rst0", 1, 16'h0102, 0, 0, 24'h0, 0, 0);
      step("rst1", 1, 16'h0304, 0, 1, 24'h010203, 0, 0);
      valid_in = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check_out("rst_async", 0, 24'h0, 0, 0);
      check("rst_async.data", 32'(data_out), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      step("rst_idle", 0, 16'h0, 0, 0, 24'h0, 0, 0);
      step("rst_a", 1, 16'hA1B2, 0, 0, 24'h0, 0, 0);
      step("rst_b", 1, 16'hC3D4, 0, 1, 24'hA1B2C3, 0, 0);
      step("rst_c", 1, 16'hE5F6, 0, 1, 24'hD4E5F6, 0, 0);
      step("rst_d", 0, 16'h0, 0, 0, 24'h0, 0, 0);

      // Randomized frames against the byte-queue model
      for (int c = 0; c < 400; c++) begin
         valid_in = ($urandom_range(0, 9) < 6);
         data_in  = 16'($urandom);
         last_in  = ($urandom_range(0, 3) == 0);
         if (valid_in) model_beat(data_in, last_in);
         @(posedge clk);
         #1;
         scoreboard_cycle("rand");
      end
      valid_in = 1'b0;
      last_in  = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk);
         #1;
         scoreboard_cycle("drain");
      end
      check("rand.pending", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
